// File: rtl/core_pkg.sv
// Shared types and constants for the 5-stage RISC-V core pipeline.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that adds 0..2^INC_W-1 per cycle; shared by the perf counters.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum;

    // The carry bit flags overflow because INC_W < W keeps the sum below 2^(W+1).
    always_comb begin
        sum     = {1'b0, count_q} + {{(W + 1 - INC_W){1'b0}}, inc_i};
        count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID boundary register with a 1-entry skid buffer, flush squashing and a squash counter.
// State table: EMPTY | no live instruction; FULL | out reg live; SKID | out reg and skid live.
module if_id_stage_reg
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [XLEN-1:0]  fetch_instr,
    output logic             fetch_ready,
    input  logic             IF_ID_flush,
    input  logic             id_stall,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_instr,
    output logic [CNT_W-1:0] squash_count
);

    stage_state_e state_q, state_d;
    if_id_t       out_q, out_d;
    if_id_t       skid_q, skid_d;
    if_id_t       fetch_word;
    logic         id_valid_q, id_valid_d;
    logic         fetch_ready_q, fetch_ready_d;
    logic         accept;
    logic         consume;
    logic [1:0]   squash_n;

    assign fetch_word = '{pc: fetch_pc, instr: fetch_instr};
    assign accept     = fetch_valid && fetch_ready_q;
    assign consume    = id_valid_q && !id_stall;

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        squash_n = 2'd0;
        if (IF_ID_flush) begin
            // A consumed instruction is still seen by decode, so only a stalled one is lost.
            state_d     = EMPTY;
            out_d.instr = NOP_INSTR;
            squash_n    = 2'(id_valid_q && id_stall) + 2'(state_q == SKID) + 2'(accept);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_d   = fetch_word;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (consume) begin
                        if (accept) begin
                            out_d = fetch_word;
                        end else begin
                            out_d.instr = NOP_INSTR;
                            state_d     = EMPTY;
                        end
                    end else if (accept) begin
                        skid_d  = fetch_word;
                        state_d = SKID;
                    end
                end
                SKID: begin
                    if (consume) begin
                        out_d   = skid_q;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        id_valid_d    = (state_d != EMPTY);
        fetch_ready_d = (state_d != SKID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            out_q         <= '{pc: '0, instr: NOP_INSTR};
            skid_q        <= '0;
            id_valid_q    <= 1'b0;
            fetch_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            skid_q        <= skid_d;
            id_valid_q    <= id_valid_d;
            fetch_ready_q <= fetch_ready_d;
        end
    end

    sat_counter #(
        .W    (CNT_W),
        .INC_W(2)
    ) u_squash_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (squash_n),
        .count_o(squash_count)
    );

    assign fetch_ready = fetch_ready_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = out_q.pc;
    assign id_instr    = out_q.instr;

endmodule
